// File: rtl/krnl_rtl_read_axi_pad_pkg.sv
// Shared types and helpers for the padded AXI4 read master.
package krnl_rtl_read_axi_pad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int BOUNDARY_LOG2 = 12;

    // Beats left before the next 4 KB page starts; a page-aligned address yields a full page.
    function automatic logic [BOUNDARY_LOG2:0] beats_to_boundary(
        input logic [BOUNDARY_LOG2-1:0] addr_lo,
        input int                       size_log2
    );
        logic [BOUNDARY_LOG2:0] bytes;
        bytes = {1'b1, {BOUNDARY_LOG2{1'b0}}} - {1'b0, addr_lo};
        return bytes >> size_log2;
    endfunction

endpackage

// File: rtl/krnl_rtl_read_axi_pad_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
module krnl_rtl_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_wr      = i_wr_en && (r_count != CW'(DEPTH));
    assign w_rd      = i_rd_en && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/krnl_rtl_read_axi_pad.sv
// AXI4 read master: splits a beat-count job into 4 KB-safe bursts, buffers R data
// in a FWFT FIFO and streams it out, zero-padding up to a minimum beat count.
module krnl_rtl_read_axi_pad
    import krnl_rtl_read_axi_pad_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 64,
    parameter int C_LENGTH_WIDTH    = 32,
    parameter int C_BURST_LEN       = 16,
    parameter int C_MAX_OUTSTANDING = 3,
    parameter int C_PAD_TO          = 128
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic                      ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]   ctrl_offset,
    input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
    output logic                      ctrl_busy,
    output logic                      ctrl_done,
    output logic                      ctrl_err,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [C_ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic                      arid,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [C_DATA_WIDTH-1:0]   rdata,
    input  logic                      rlast,
    input  logic [1:0]                rresp,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [C_DATA_WIDTH-1:0]   m_tdata,
    output logic                      m_tlast
);

    localparam int SIZE_LOG2  = $clog2(C_DATA_WIDTH / 8);
    localparam int FIFO_DEPTH = C_BURST_LEN * (C_MAX_OUTSTANDING + 1);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int CRW        = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int NW         = C_LENGTH_WIDTH + 1;
    localparam int XW0        = (C_LENGTH_WIDTH > CW) ? C_LENGTH_WIDTH : CW;
    localparam int XW         = (XW0 > 16) ? XW0 : 16;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [C_ADDR_WIDTH-1:0]   r_addr;
    logic [C_LENGTH_WIDTH-1:0] r_remaining;
    logic [C_LENGTH_WIDTH-1:0] r_length;
    logic [NW-1:0]             r_out_cnt;
    logic [CRW-1:0]            r_credit;
    logic [CW-1:0]             r_inflight;
    logic                      r_arvalid;
    logic [C_ADDR_WIDTH-1:0]   r_araddr;
    logic [7:0]                r_arlen;
    logic                      r_err;

    logic                      w_start_ok;
    logic [C_ADDR_WIDTH-1:0]   w_offset_al;
    logic [C_ADDR_WIDTH-1:0]   w_src_addr;
    logic [C_LENGTH_WIDTH-1:0] w_src_rem;
    logic [BOUNDARY_LOG2:0]    w_to_4k;
    logic [XW-1:0]             w_beats;
    logic [XW-1:0]             w_room;
    logic                      w_issue;
    logic                      w_ar_hs;
    logic                      w_out_hs;
    logic [NW-1:0]             w_n_out;
    logic [NW-1:0]             w_len_ext;
    logic                      w_fifo_rd;
    logic                      w_fifo_empty;
    logic [C_DATA_WIDTH-1:0]   w_fifo_dout;
    logic [CW-1:0]             w_fifo_count;

    assign arvalid = r_arvalid;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = 3'(SIZE_LOG2);
    assign arid    = 1'b0;
    assign rready  = 1'b1;
    assign ctrl_err = r_err;

    assign w_start_ok  = ctrl_start && (r_state == ST_IDLE);
    assign w_offset_al = ctrl_offset & ~C_ADDR_WIDTH'(C_DATA_WIDTH / 8 - 1);
    assign w_len_ext   = {1'b0, r_length};
    assign w_n_out     = (w_len_ext >= NW'(C_PAD_TO)) ? w_len_ext : NW'(C_PAD_TO);
    assign w_ar_hs     = r_arvalid && arready;
    assign w_out_hs    = m_tvalid && m_tready;

    // The first burst is sized straight from the start inputs so arvalid rises one cycle after start.
    assign w_src_addr = (r_state == ST_IDLE) ? w_offset_al : r_addr;
    assign w_src_rem  = (r_state == ST_IDLE) ? ctrl_length : r_remaining;
    assign w_to_4k    = beats_to_boundary(w_src_addr[BOUNDARY_LOG2-1:0], SIZE_LOG2);

    always_comb begin
        w_beats = XW'(w_src_rem);
        if (w_beats > XW'(C_BURST_LEN)) w_beats = XW'(C_BURST_LEN);
        if (w_beats > XW'(w_to_4k))     w_beats = XW'(w_to_4k);
    end

    // Space is reserved at issue time, so the FIFO can never overflow with rready tied high.
    assign w_room  = XW'(FIFO_DEPTH) - XW'(w_fifo_count) - XW'(r_inflight);
    assign w_issue = (w_start_ok && (ctrl_length != '0)) ||
                     ((r_state == ST_RUN) && !r_arvalid && (r_remaining != '0) &&
                      (r_credit != '0) && (w_room >= w_beats));

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) r_state <= ST_IDLE;
        else           r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) begin
                if (ctrl_length != '0)  w_next_state = ST_RUN;
                else if (C_PAD_TO == 0) w_next_state = ST_DONE;
                else                    w_next_state = ST_PAD;
            end
            ST_RUN: if (w_out_hs && (r_out_cnt == w_len_ext - 1'b1))
                w_next_state = (w_len_ext < NW'(C_PAD_TO)) ? ST_PAD : ST_DONE;
            ST_PAD: if (w_out_hs && (r_out_cnt == w_n_out - 1'b1))
                w_next_state = ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_busy = 1'b0;
        ctrl_done = 1'b0;
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        w_fifo_rd = 1'b0;
        case (r_state)
            ST_RUN: begin
                ctrl_busy = 1'b1;
                m_tvalid  = !w_fifo_empty;
                m_tdata   = w_fifo_empty ? '0 : w_fifo_dout;
                w_fifo_rd = m_tready;
            end
            ST_PAD:  begin
                ctrl_busy = 1'b1;
                m_tvalid  = 1'b1;
            end
            ST_DONE: ctrl_done = 1'b1;
            default: ;
        endcase
        m_tlast = m_tvalid && (r_out_cnt == w_n_out - 1'b1);
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_length    <= '0;
            r_out_cnt   <= '0;
            r_credit    <= CRW'(C_MAX_OUTSTANDING);
            r_inflight  <= '0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_length  <= ctrl_length;
                r_out_cnt <= '0;
                r_err     <= 1'b0;
            end else begin
                if (w_out_hs) r_out_cnt <= r_out_cnt + 1'b1;
                if (rvalid && (rresp != 2'b00)) r_err <= 1'b1;
            end

            if (w_issue) begin
                r_arvalid   <= 1'b1;
                r_araddr    <= w_src_addr;
                r_arlen     <= 8'(w_beats - 1'b1);
                r_addr      <= w_src_addr + (C_ADDR_WIDTH'(w_beats) << SIZE_LOG2);
                r_remaining <= w_src_rem - C_LENGTH_WIDTH'(w_beats);
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end

            r_inflight <= r_inflight + (w_issue ? CW'(w_beats) : '0) - CW'(rvalid);

            case ({w_ar_hs, rvalid && rlast})
                2'b10:   r_credit <= r_credit - 1'b1;
                2'b01:   r_credit <= r_credit + 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    krnl_rtl_sync_fifo #(
        .WIDTH (C_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (aclk),
        .i_rst_n   (areset_n),
        .i_wr_en   (rvalid),
        .i_wr_data (rdata),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_fifo_dout),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

endmodule

// File: tb/tb_krnl_rtl_read_axi_pad.sv
// Directed-plus-random bench for krnl_rtl_read_axi_pad with a behavioural AXI slave and stream model.
module tb_krnl_rtl_read_axi_pad;

  localparam int PAD = 128;
  localparam int TIMEOUT = 6000;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        ctrl_start;
  logic [63:0] ctrl_offset;
  logic [31:0] ctrl_length;
  logic        ctrl_busy, ctrl_done, ctrl_err;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arid;
  logic        rvalid, rready, rlast;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        m_tvalid, m_tready, m_tlast;
  logic [63:0] m_tdata;

  krnl_rtl_read_axi_pad dut (
    .aclk(aclk), .areset_n(areset_n), .ctrl_start(ctrl_start), .ctrl_offset(ctrl_offset),
    .ctrl_length(ctrl_length), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_err(ctrl_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arid(arid), .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  // stimulus knobs
  logic        drv_start = 1'b0;
  logic [63:0] drv_off = '0;
  logic [31:0] drv_len = '0;
  logic        ar_rand = 1'b0, tready_rand = 1'b0, r_stall = 1'b0;
  int          r_prob = 100, tready_hold = 0;

  // AXI slave model
  logic [63:0] rb_addr[$];
  logic [7:0]  rb_len[$];
  int          rb_beat = 0, r_glob = 0, r_err_idx = -1;
  logic [31:0] seed = 32'h1234_5678;

  // scoreboard
  logic [71:0] exp_ar[$];
  logic [63:0] exp_q[$];
  int          out_idx = 0, n_out = 0, job_len = 0;
  int          ar_cnt = 0, rlast_cnt = 0, rcv_cnt = 0, real_out = 0, max_occ = 0;
  logic        m_busy = 1'b0, m_err = 1'b0, m_done_pend = 1'b0;
  logic        prev_ar_wait = 1'b0, prev_tstall = 1'b0, prev_tlast = 1'b0;
  logic [63:0] prev_araddr = '0, prev_tdata = '0;
  logic [7:0]  prev_arlen = '0;

  function automatic logic [63:0] fdata(input logic [63:0] a);
    return {a[31:0] ^ seed, ~a[31:0]};
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    logic        start_acc;
    logic [71:0] e_ar;
    logic [63:0] e_d;
    int          occ;
    start_acc = ctrl_start && !m_busy && !m_done_pend;
    check("busy", ctrl_busy, m_busy);
    check("done", ctrl_done, m_done_pend);
    check("err", ctrl_err, m_err);
    m_done_pend = 1'b0;
    if (prev_ar_wait) check("ar_hold", {arvalid, araddr, arlen}, {1'b1, prev_araddr, prev_arlen});
    if (arvalid && arready) begin
      ar_cnt++;
      e_ar = (exp_ar.size() > 0) ? exp_ar.pop_front() : '1;
      check("ar", {araddr, arlen}, e_ar);
      check("ar_credit", (ar_cnt - rlast_cnt) <= 3, 1'b1);
      rb_addr.push_back(araddr);
      rb_len.push_back(arlen);
    end
    prev_ar_wait = arvalid && !arready;
    prev_araddr  = araddr;
    prev_arlen   = arlen;
    if (rvalid) begin
      if (rresp != 2'd0) m_err = 1'b1;
      rcv_cnt++;
      rb_beat++;
      r_glob++;
      if (rlast) begin
        rlast_cnt++;
        void'(rb_addr.pop_front());
        void'(rb_len.pop_front());
        rb_beat = 0;
      end
    end
    if (prev_tstall) check("t_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_tlast, prev_tdata});
    if (m_tvalid && m_tready) begin
      e_d = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("tdata", m_tdata, e_d);
      check("tlast", m_tlast, out_idx == n_out - 1);
      if (out_idx < job_len) real_out++;
      if (out_idx == n_out - 1) begin
        m_busy = 1'b0;
        m_done_pend = 1'b1;
      end
      out_idx++;
    end
    prev_tstall = m_tvalid && !m_tready;
    prev_tlast  = m_tlast;
    prev_tdata  = m_tdata;
    occ = rcv_cnt - real_out;
    if (occ > max_occ) max_occ = occ;
    if (start_acc) begin
      m_busy = 1'b1;
      m_err  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    ctrl_start  = drv_start;
    ctrl_offset = drv_off;
    ctrl_length = drv_len;
    drv_start   = 1'b0;
    arready = ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!r_stall && rb_addr.size() > 0 && $urandom_range(0, 99) < r_prob) begin
      rvalid = 1'b1;
      rdata  = fdata(rb_addr[0] + 64'(rb_beat * 8));
      rlast  = (rb_beat == int'(rb_len[0]));
      rresp  = (r_glob == r_err_idx) ? 2'd2 : 2'd0;
    end else begin
      rvalid = 1'b0;
      rdata  = {$urandom, $urandom};
      rlast  = 1'b0;
      rresp  = 2'd0;
    end
    if (tready_hold > 0) begin
      m_tready = 1'b0;
      tready_hold--;
    end else begin
      m_tready = tready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    @(negedge aclk);
    if (areset_n) observe();
  endtask

  // Builds the expected AR list and output stream from the burst-splitting and padding rules.
  task automatic prep_job(input logic [63:0] off, input int len);
    logic [63:0] a;
    int rem, b, to4k;
    seed = $urandom;
    job_len = len;
    n_out = (len > PAD) ? len : PAD;
    out_idx = 0;
    real_out = 0;
    rcv_cnt = 0;
    max_occ = 0;
    exp_ar.delete();
    exp_q.delete();
    a = off & ~64'h7;
    for (int i = 0; i < len; i++) exp_q.push_back(fdata(a + 64'(i) * 64'd8));
    for (int i = len; i < n_out; i++) exp_q.push_back(64'd0);
    rem = len;
    while (rem > 0) begin
      to4k = (4096 - int'(a % 64'd4096)) / 8;
      b = rem;
      if (b > 16) b = 16;
      if (b > to4k) b = to4k;
      exp_ar.push_back({a, 8'(b - 1)});
      a = a + 64'(b * 8);
      rem -= b;
    end
    drv_off = off;
    drv_len = 32'(len);
  endtask

  task automatic run_job(input logic [63:0] off, input int len, input int stall_cyc,
                         input int hold_cyc, input logic poke);
    int cyc, ar0;
    prep_job(off, len);
    ar0 = ar_cnt;
    tready_hold = hold_cyc;
    drv_start = 1'b1;
    tick();
    tick();
    check("ar_first", arvalid, len > 0);
    if (stall_cyc > 0) begin
      r_stall = 1'b1;
      repeat (stall_cyc) tick();
      check("ar_outstanding_cap", ar_cnt - ar0, 3);
      r_stall = 1'b0;
    end
    cyc = 0;
    while ((m_busy || m_done_pend) && cyc < TIMEOUT) begin
      if (poke && cyc == 10) begin
        drv_off = 64'h5000;
        drv_len = 32'd3;
        drv_start = 1'b1;
      end
      tick();
      cyc++;
    end
    check("timeout", cyc < TIMEOUT, 1'b1);
    check("stream_left", exp_q.size(), 0);
    check("ar_left", exp_ar.size(), 0);
    check("fifo_bound", max_occ <= 64, 1'b1);
  endtask

  initial begin
    logic [63:0] off;
    areset_n = 1'b0;
    ctrl_start = 1'b0; ctrl_offset = '0; ctrl_length = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'd0; m_tready = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_state", {arvalid, araddr, arlen, ctrl_busy, ctrl_done, ctrl_err},
          {1'b1 & 1'b0, 64'd0, 8'd0, 3'd0});
    check("rst_stream", {m_tvalid, m_tlast, m_tdata}, 66'd0);
    check("const_ports", {arsize, arid, rready}, {3'd3, 1'b0, 1'b1});
    @(posedge aclk);
    #1 areset_n = 1'b1;
    repeat (2) tick();

    // 40 beats from 0: three bursts, then 88 pad beats; a start while busy must be ignored
    run_job(64'h0, 40, 0, 0, 1'b1);
    // 4 KB split at 0xFC0 with random handshakes
    ar_rand = 1'b1; tready_rand = 1'b1; r_prob = 60;
    run_job(64'hFC0, 32, 0, 0, 1'b0);
    // R channel stalled: only three bursts may be outstanding
    ar_rand = 1'b0;
    run_job(64'h0, 200, 40, 0, 1'b0);
    // output stalled for 200 cycles during a 64-beat job
    r_prob = 100; tready_rand = 1'b0;
    run_job(64'h2000, 64, 0, 200, 1'b0);
    // zero length: pad only
    run_job(64'h40, 0, 0, 0, 1'b0);
    // an error response sets the sticky flag; the next start clears it
    r_err_idx = r_glob + 5;
    run_job(64'h300, 20, 0, 0, 1'b0);
    check("err_sticky", ctrl_err, 1'b1);
    r_err_idx = -1;
    run_job(64'h18, 150, 0, 0, 1'b0);

    for (int j = 0; j < 4; j++) begin
      ar_rand = 1'b1; tready_rand = 1'b1; r_prob = $urandom_range(40, 100);
      off = 64'(4096 * $urandom_range(1, 8)) - 64'(8 * $urandom_range(0, 40)) + 64'($urandom_range(0, 7));
      run_job(off, $urandom_range(1, 300), 0, 0, 1'b0);
    end

    // asynchronous reset in the middle of a job, slave held idle
    ar_rand = 1'b0; tready_rand = 1'b0; r_prob = 100;
    prep_job(64'h800, 100);
    drv_start = 1'b1;
    repeat (20) tick();
    @(posedge aclk);
    #2 areset_n = 1'b0;
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("midrst_clear", {arvalid, ctrl_busy, ctrl_done, ctrl_err, m_tvalid, m_tlast, m_tdata},
          70'd0);
    rb_addr.delete(); rb_len.delete(); rb_beat = 0;
    ar_cnt = 0; rlast_cnt = 0;
    m_busy = 1'b0; m_err = 1'b0; m_done_pend = 1'b0;
    prev_ar_wait = 1'b0; prev_tstall = 1'b0;
    @(posedge aclk);
    #1 areset_n = 1'b1;
    tick();
    run_job(64'hA08, 24, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/krnl_rtl_read_axi_pad.md
# krnl_rtl_read_axi_pad

Parametrised AXI4 read master for kernel input streams. It fetches `ctrl_length` beats starting at `ctrl_offset` and issues bursts of configurable length, split at 4 KB boundaries, with credit-based outstanding control. Data is delivered on an AXI-Stream-style output through an internal FWFT FIFO. The stream is optionally zero-padded up to a fixed minimum beat count, which generalises the fixed 128-entry fill of the previous reader. It sits between the kernel control registers and the compute datapath.

## Interface
Parameters:
- C_ADDR_WIDTH, 64, AXI address width
- C_DATA_WIDTH, 64, data width; power of two, 32..512
- C_LENGTH_WIDTH, 32, width of the beat count
- C_BURST_LEN, 16, maximum beats per burst; power of two, 1..256
- C_MAX_OUTSTANDING, 3, maximum AR bursts in flight
- C_PAD_TO, 128, minimum output beats per job; 0 disables padding

Ports:
- aclk  in  1  clock
- areset_n  in  1  reset; one clock, asynchronous, active-low
- ctrl_start  in  1  job start pulse; ignored unless idle
- ctrl_offset  in  C_ADDR_WIDTH  byte address; low log2(C_DATA_WIDTH/8) bits forced to 0
- ctrl_length  in  C_LENGTH_WIDTH  job length in beats
- ctrl_busy  out  1  high from the accepted start until ctrl_done
- ctrl_done  out  1  one-cycle pulse at job end
- ctrl_err  out  1  sticky; set by any rresp != 0; cleared by an accepted start
- arvalid / arready  out / in  1  AR handshake
- araddr  out  C_ADDR_WIDTH  burst address
- arlen  out  8  burst length minus 1
- arsize  out  3  log2(C_DATA_WIDTH/8), constant
- arid  out  1  constant 0
- rvalid  in  1  R data valid
- rready  out  1  constant 1
- rdata  in  C_DATA_WIDTH  R data
- rlast  in  1  last beat of burst
- rresp  in  2  read response
- m_tvalid / m_tready  out / in  1  output stream handshake
- m_tdata  out  C_DATA_WIDTH  output data
- m_tlast  out  1  marks the final output beat of the job

## Operation
- Total output beats: N_out = max(ctrl_length, C_PAD_TO).
- States and transitions:
  - IDLE: an accepted ctrl_start latches offset and length and moves to RUN. If ctrl_length = 0, go straight to PAD, or to DONE when C_PAD_TO = 0.
  - RUN: issues AR bursts and receives R data. Moves to PAD once all real beats have been output and the output count is below C_PAD_TO; otherwise moves to DONE after the final handshake.
  - PAD: drives m_tvalid=1 with m_tdata=0 until N_out beats have been output.
  - DONE: lasts one cycle; pulses ctrl_done, then returns to IDLE.
- Burst length: beats = min(remaining, C_BURST_LEN, beats to the next 4 KB boundary); arlen = beats − 1. The next address is araddr + beats·C_DATA_WIDTH/8.
- An AR is issued only when both hold:
  - outstanding credit > 0;
  - FIFO_DEPTH − occupancy − in-flight beats ≥ beats.
  - This guarantees the FIFO never overflows, so rready may be tied high.
- Credit accounting:
  - Credit decrements on an AR handshake and increments on an R beat with rlast.
  - If both happen in the same cycle, credit is unchanged.
- FIFO_DEPTH = C_BURST_LEN·(C_MAX_OUTSTANDING+1).
- Every R beat is written to the FIFO regardless of rresp. An error response only sets ctrl_err.
- Output beat counter is C_LENGTH_WIDTH+1 bits wide. m_tlast is high when the counter equals N_out − 1.

## Timing
- Reset values: arvalid=0, araddr=0, arlen=0, ctrl_busy=0, ctrl_done=0, ctrl_err=0, m_tvalid=0, m_tdata=0, m_tlast=0, FIFO empty, credit=C_MAX_OUTSTANDING.
- arvalid is registered. First AR: start sampled at cycle T gives arvalid=1 at T+1.
- arvalid holds, with araddr and arlen stable, until arready is sampled high.
- FWFT latency: an R beat accepted at cycle t appears as m_tvalid/m_tdata at t+1.
- m_tdata and m_tlast stay stable while m_tvalid=1 and m_tready=0.
- The first pad beat is presented in the cycle after the last real beat's handshake. There are no bubbles between consecutive pad beats.
- ctrl_done fires in the cycle after the handshake of beat N_out−1. ctrl_busy drops in that same cycle.
- ctrl_start while busy is ignored, with no effect on any output.
- Asserting areset_n low mid-job clears everything asynchronously. The system must hold the AXI slave idle across reset, because in-flight responses are not drained.

## Structure
- Shared package: state encoding, the 4 KB constant (12), and a function computing beats to the boundary.
- One sub-module, `krnl_rtl_sync_fifo`:
  - parametrised width and depth;
  - FWFT read, async active-low reset;
  - provides an occupancy count output.

## Test plan
- C_BURST_LEN=16, offset 0x0, length 40, arready always high, m_tready=1:
  - ARs are arlen 15, 15, 7 at 0x0, 0x80, 0x100;
  - 40 data beats are followed by 88 zero beats;
  - m_tlast is on beat 127; one ctrl_done pulse.
- Offset 0xFC0, length 32, 64-bit data: ARs are arlen 7 at 0xFC0, arlen 15 at 0x1000, arlen 7 at 0x1080.
- R data stalled with C_MAX_OUTSTANDING=3: exactly 3 ARs are issued, then none until an rlast arrives.
- m_tready=0 for 200 cycles during a 64-beat job: the FIFO never exceeds 64 entries, no data is lost, and the output order is preserved.
- Length 0, C_PAD_TO=4: no AR is issued; 4 zero beats are output with m_tlast on the 4th; ctrl_done follows.
- rresp=2 on a single beat: ctrl_err=1 until the next accepted start, and the data stream is unaffected.
